// File: rtl/vmem_pkg.sv
// Shared types and defaults for the vector memory sequencer.
package vmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      COMMIT = 2'd2
   } vmem_state_t;

   localparam int unsigned DEF_LANES  = 4;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned LANE_BYTES = DEF_DATA_W / 8;

   function automatic int unsigned lane_bytes(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/vmem_lane_buf.sv
// Per-lane capture registers for vector loads, presented as one flat vector.
module vmem_lane_buf
   import vmem_pkg::*;
#(
   parameter int unsigned LANES  = DEF_LANES,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    we,
   input  logic [IDX_W-1:0]        idx,
   input  logic [DATA_W-1:0]       wdata,
   output logic [LANES*DATA_W-1:0] vdst
);

   logic [DATA_W-1:0] lanes_q [LANES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LANES; i++) lanes_q[i] <= '0;
      end else if (clr) begin
         for (int unsigned i = 0; i < LANES; i++) lanes_q[i] <= '0;
      end else if (we) begin
         lanes_q[idx] <= wdata;
      end
   end

   always_comb begin
      vdst = '0;
      for (int unsigned i = 0; i < LANES; i++) vdst[i*DATA_W +: DATA_W] = lanes_q[i];
   end

endmodule

// File: rtl/vmem_sequencer.sv
// Multicycle vld/vst sequencer: one lane access per memory handshake, single vector commit.
// Optional per-lane masking is enabled by defining VMEM_LANE_MASK_EN.
module vmem_sequencer
   import vmem_pkg::*;
#(
   parameter int unsigned LANES  = DEF_LANES,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    is_store,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [LANES*DATA_W-1:0] vsrc,
`ifdef VMEM_LANE_MASK_EN
   input  logic [LANES-1:0]        lane_mask,
`endif
   output logic                    stall,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   input  logic                    mem_ack,
   input  logic [DATA_W-1:0]       mem_rdata,
   output logic [LANES*DATA_W-1:0] vdst,
   output logic                    vdst_we,
   output logic                    done
);

   localparam int unsigned      IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned      LB    = lane_bytes(DATA_W);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(LANES - 1);

   vmem_state_t               state;
   logic [IDX_W-1:0]          idx;
   logic                      store_q;
   logic [ADDR_W-1:0]         base_q;
   logic [LANES*DATA_W-1:0]   vsrc_q;

   logic                      in_idle, in_access, in_commit;
   logic                      lane_last, none;
   logic [IDX_W-1:0]          lane_next, lane_first;

`ifdef VMEM_LANE_MASK_EN
   logic [LANES-1:0]          mask_q;

   // First set lane of the incoming mask, and next set lane above idx in the latched mask.
   always_comb begin
      lane_first = '0;
      none       = 1'b1;
      lane_next  = '0;
      lane_last  = 1'b1;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (none && lane_mask[k]) begin
            none       = 1'b0;
            lane_first = IDX_W'(k);
         end
         if (lane_last && (k > 32'(idx)) && mask_q[k]) begin
            lane_last = 1'b0;
            lane_next = IDX_W'(k);
         end
      end
   end
`else
   assign lane_first = '0;
   assign none       = 1'b0;
   assign lane_next  = idx + 1'b1;
   assign lane_last  = (idx == LAST);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         store_q <= 1'b0;
         base_q  <= '0;
         vsrc_q  <= '0;
`ifdef VMEM_LANE_MASK_EN
         mask_q  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  store_q <= is_store;
                  base_q  <= base_addr;
                  vsrc_q  <= vsrc;
                  idx     <= lane_first;
`ifdef VMEM_LANE_MASK_EN
                  mask_q  <= lane_mask;
`endif
                  state   <= none ? COMMIT : ACCESS;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  if (lane_last) state <= COMMIT;
                  else           idx   <= lane_next;
               end
            end
            COMMIT:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_idle   = (state == IDLE);
   assign in_access = (state == ACCESS);
   assign in_commit = (state == COMMIT);

   // rst_n gates stall so every output is low while reset is held.
   assign stall     = rst_n & ((in_idle & start) | in_access);
   assign mem_req   = in_access;
   assign mem_we    = in_access & store_q;
   assign mem_addr  = in_access ? (base_q + ADDR_W'(idx) * ADDR_W'(LB)) : '0;
   assign mem_wdata = in_access ? vsrc_q[idx*DATA_W +: DATA_W] : '0;
   assign done      = in_commit;
   assign vdst_we   = in_commit & ~store_q;

   vmem_lane_buf #(
      .LANES  (LANES),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (in_idle & start & ~is_store),
      .we    (in_access & mem_ack & ~store_q),
      .idx   (idx),
      .wdata (mem_rdata),
      .vdst  (vdst)
   );

endmodule
